// File: rtl/conv_mesh_pkg.sv
// Shared types, width helpers and the drain rescale function for the streaming PE mesh.
// Build option: CONV_MESH_SAT_EN selects saturating rescale instead of wrapping truncation.
package conv_mesh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_WORD = 64;
    localparam int WIDE     = 128;

    function automatic int rowIdxWidth(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int shiftWidth(input int accw);
        return (accw > 1) ? $clog2(accw) : 1;
    endfunction

    // The caller keeps the low w bits of the result; value is already shifted and sign-extended.
    function automatic logic [MAX_WORD-1:0] rescaleWord(input logic signed [WIDE-1:0] value,
                                                        input int w);
`ifdef CONV_MESH_SAT_EN
        logic signed [WIDE-1:0] one;
        logic signed [WIDE-1:0] maxV;
        logic signed [WIDE-1:0] minV;
        one  = 1;
        maxV = (one <<< (w - 1)) - one;
        minV = -(one <<< (w - 1));
        if (value > maxV) begin
            return maxV[MAX_WORD-1:0];
        end else if (value < minV) begin
            return minV[MAX_WORD-1:0];
        end else begin
            return value[MAX_WORD-1:0];
        end
`else
        if (w < 1) begin
            return '0;
        end
        return value[MAX_WORD-1:0];
`endif
    endfunction

endpackage

// File: rtl/conv_mac_cell.sv
// One signed multiply-accumulate cell of the mesh: single-cycle product added into a
// wrapping ACCW-bit accumulator, with synchronous clear and enable.
module conv_mac_cell #(
    parameter int W    = 16,
    parameter int ACCW = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_en,
    input  logic signed [W-1:0]    i_k,
    input  logic signed [W-1:0]    i_n,
    output logic signed [ACCW-1:0] o_acc
);

    logic signed [2*W-1:0]  w_prod;
    logic signed [ACCW-1:0] r_acc;

    assign w_prod = i_k * i_n;

    // Clear wins over enable so a new job always starts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACCW'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_mesh_stream.sv
// ROWSxCOLS output-stationary signed MAC mesh with an internal IDLE/ACC/DRAIN job FSM and a
// valid/ready row drain. Build option: CONV_MESH_SAT_EN (saturating drain rescale).
module conv_mesh_stream
    import conv_mesh_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int W    = 16,
    parameter int ACCW = 32,
    parameter int LW   = 8,
    localparam int RW  = rowIdxWidth(ROWS),
    localparam int SW  = shiftWidth(ACCW)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [LW-1:0]     i_cfg_len,
    input  logic [SW-1:0]     i_cfg_shift,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [W*ROWS-1:0] i_kBuffIn,
    input  logic [W*COLS-1:0] i_nBuffIn,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [W*COLS-1:0] o_out_data,
    output logic [RW-1:0]     o_out_row,
    output logic              o_out_last,
    output logic              o_busy
);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t          r_state;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_count;
    logic [SW-1:0]   r_shift;
    logic [RW-1:0]   r_row;
    logic            r_cfgReady;
    logic            r_inReady;
    logic            r_outValid;
    logic            r_outLast;
    logic            r_busy;

    logic            w_cfgFire;
    logic            w_beatFire;
    logic            w_outFire;

    logic signed [ACCW-1:0]   w_acc [ROWS][COLS];
    logic signed [ACCW-1:0]   w_shifted [COLS];
    logic signed [WIDE-1:0]   w_wide [COLS];
    logic [MAX_WORD-1:0]      w_rescaled [COLS];

    assign w_cfgFire  = (r_state == IDLE) && i_cfg_valid;
    assign w_beatFire = (r_state == ACC) && i_in_valid;
    assign w_outFire  = r_outValid && i_out_ready;

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            conv_mac_cell #(
                .W    (W),
                .ACCW (ACCW)
            ) u_cell (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_clear (w_cfgFire),
                .i_en    (w_beatFire),
                .i_k     (i_kBuffIn[W*(gr+1)-1 -: W]),
                .i_n     (i_nBuffIn[W*(gc+1)-1 -: W]),
                .o_acc   (w_acc[gr][gc])
            );
        end
    end

    // Drain path: select the current row, shift arithmetically, then wrap or saturate to W bits.
    for (genvar gc = 0; gc < COLS; gc++) begin : g_drain
        assign w_shifted[gc]  = w_acc[r_row][gc] >>> r_shift;
        assign w_wide[gc]     = WIDE'(w_shifted[gc]);
        assign w_rescaled[gc] = rescaleWord(w_wide[gc], W);
        assign o_out_data[W*(gc+1)-1 -: W] = r_outValid ? w_rescaled[gc][W-1:0] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_len      <= LW'(1);
            r_count    <= '0;
            r_shift    <= '0;
            r_row      <= '0;
            r_cfgReady <= 1'b1;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cfgFire) begin
                        r_len      <= (i_cfg_len == '0) ? LW'(1) : i_cfg_len;
                        r_shift    <= i_cfg_shift;
                        r_count    <= '0;
                        r_state    <= ACC;
                        r_cfgReady <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ACC: begin
                    if (w_beatFire) begin
                        r_count <= r_count + LW'(1);
                        if (r_count == r_len - LW'(1)) begin
                            r_state    <= DRAIN;
                            r_inReady  <= 1'b0;
                            r_outValid <= 1'b1;
                            r_row      <= '0;
                            r_outLast  <= (LAST_ROW == '0);
                        end
                    end
                end
                DRAIN: begin
                    if (w_outFire) begin
                        if (r_row == LAST_ROW) begin
                            r_state    <= IDLE;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            r_row      <= '0;
                            r_cfgReady <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_row     <= r_row + RW'(1);
                            r_outLast <= ((r_row + RW'(1)) == LAST_ROW);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cfgReady <= 1'b1;
                    r_inReady  <= 1'b0;
                    r_outValid <= 1'b0;
                    r_outLast  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_row      <= '0;
                end
            endcase
        end
    end

    assign o_cfg_ready = r_cfgReady;
    assign o_in_ready  = r_inReady;
    assign o_out_valid = r_outValid;
    assign o_out_last  = r_outLast;
    assign o_out_row   = r_row;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_conv_mesh_stream.sv
// Self-checking bench for conv_mesh_stream: directed scenarios plus randomized jobs checked
// against an arithmetic model of the mesh. Honors CONV_MESH_SAT_EN like the design.
module tb_conv_mesh_stream;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 16;
    localparam int ACCW = 32;
    localparam int LW   = 8;
    localparam int SW   = 5;
    localparam int RW   = 2;

    logic              clk;
    logic              rstN;
    logic              cfgValid;
    logic              cfgReady;
    logic [LW-1:0]     cfgLen;
    logic [SW-1:0]     cfgShift;
    logic              inValid;
    logic              inReady;
    logic [W*ROWS-1:0] kIn;
    logic [W*COLS-1:0] nIn;
    logic              outValid;
    logic              outReady;
    logic [W*COLS-1:0] outData;
    logic [RW-1:0]     outRow;
    logic              outLast;
    logic              busy;

    int nCompared;
    int nMismatch;

    logic signed [ACCW-1:0] mAcc [ROWS][COLS];
    int                     mShift;

    logic [W*COLS-1:0] obsData [ROWS];
    int                obsRow  [ROWS];
    logic              obsLast [ROWS];
    int                obsCount;
    logic              timedOut;

    conv_mesh_stream #(
        .ROWS (ROWS),
        .COLS (COLS),
        .W    (W),
        .ACCW (ACCW),
        .LW   (LW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_cfg_valid (cfgValid),
        .o_cfg_ready (cfgReady),
        .i_cfg_len   (cfgLen),
        .i_cfg_shift (cfgShift),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_kBuffIn   (kIn),
        .i_nBuffIn   (nIn),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_data  (outData),
        .o_out_row   (outRow),
        .o_out_last  (outLast),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: each cell is the wrapped sum of signed products; drain is shift then wrap/saturate.
    function automatic void modelClear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mAcc[r][c] = '0;
    endfunction

    function automatic void modelBeat(input logic [W*ROWS-1:0] k, input logic [W*COLS-1:0] n);
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        longint p;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                a = k[W*r +: W];
                b = n[W*c +: W];
                p = longint'(a) * longint'(b);
                mAcc[r][c] = mAcc[r][c] + p[ACCW-1:0];
            end
        end
    endfunction

    function automatic logic [W*COLS-1:0] expRow(input int r);
        logic [W*COLS-1:0] res;
        longint v;
        for (int c = 0; c < COLS; c++) begin
            v = longint'(mAcc[r][c]) >>> mShift;
`ifdef CONV_MESH_SAT_EN
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
`endif
            res[W*c +: W] = v[W-1:0];
        end
        return res;
    endfunction

    // Stimulus helpers; all are entered and left on a falling edge.
    task automatic startJob(input int len, input int shift);
        cfgValid = 1'b1;
        cfgLen   = len[LW-1:0];
        cfgShift = shift[SW-1:0];
        @(negedge clk);
        cfgValid = 1'b0;
        modelClear();
        mShift = shift;
    endtask

    task automatic beat(input logic [W*ROWS-1:0] k, input logic [W*COLS-1:0] n);
        inValid = 1'b1;
        kIn     = k;
        nIn     = n;
        modelBeat(k, n);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic collectDrain(input bit randomReady);
        bit done;
        done     = 1'b0;
        obsCount = 0;
        timedOut = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            if (outValid) begin
                outReady = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (outReady) begin
                    if (obsCount < ROWS) begin
                        obsData[obsCount] = outData;
                        obsRow[obsCount]  = int'(outRow);
                        obsLast[obsCount] = outLast;
                    end
                    obsCount++;
                    if (outLast || obsCount > ROWS) done = 1'b1;
                end
            end else begin
                outReady = 1'b0;
            end
            @(negedge clk);
        end
        outReady = 1'b0;
        if (!done) timedOut = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        nCompared += 7;
        if (cfgReady !== 1'b1) begin nMismatch++; $display("[TB] FAIL reset_cfg_ready got %b want 1", cfgReady); end
        if (inReady !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_in_ready got %b want 0", inReady); end
        if (outValid !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_out_valid got %b want 0", outValid); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (outData !== '0) begin nMismatch++; $display("[TB] FAIL reset_out_data got %h want 0", outData); end
        if (outRow !== '0) begin nMismatch++; $display("[TB] FAIL reset_out_row got %0d want 0", outRow); end
        if (outLast !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_out_last got %b want 0", outLast); end
    endtask

    task automatic test_basic();
        startJob(3, 0);
        nCompared++;
        if (inReady !== 1'b1) begin nMismatch++; $display("[TB] FAIL basic_in_ready got %b want 1", inReady); end
        beat({ROWS{16'd1}}, {COLS{16'd2}});
        cfgValid = 1'b1;
        cfgLen   = 8'd7;
        beat({ROWS{16'd1}}, {COLS{16'd2}});
        cfgValid = 1'b0;
        beat({ROWS{16'd1}}, {COLS{16'd2}});
        nCompared += 2;
        if (outValid !== 1'b1) begin nMismatch++; $display("[TB] FAIL basic_latency out_valid got %b want 1", outValid); end
        if (inReady !== 1'b0) begin nMismatch++; $display("[TB] FAIL basic_in_ready_drain got %b want 0", inReady); end
        collectDrain(1'b0);
        nCompared += 2;
        if (timedOut !== 1'b0) begin nMismatch++; $display("[TB] FAIL basic_timeout got %b want 0", timedOut); end
        if (obsCount !== ROWS) begin nMismatch++; $display("[TB] FAIL basic_rows got %0d want %0d", obsCount, ROWS); end
        for (int r = 0; r < ROWS && r < obsCount; r++) begin
            nCompared += 3;
            if (obsData[r] !== {COLS{16'h0006}}) begin nMismatch++; $display("[TB] FAIL basic_data row %0d got %h want %h", r, obsData[r], {COLS{16'h0006}}); end
            if (obsRow[r] !== r) begin nMismatch++; $display("[TB] FAIL basic_row_idx got %0d want %0d", obsRow[r], r); end
            if (obsLast[r] !== (r == ROWS - 1)) begin nMismatch++; $display("[TB] FAIL basic_last row %0d got %b", r, obsLast[r]); end
        end
        nCompared += 2;
        if (cfgReady !== 1'b1) begin nMismatch++; $display("[TB] FAIL basic_idle_cfg_ready got %b want 1", cfgReady); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_negative_shift();
        startJob(1, 1);
        beat({ROWS{16'hFFFD}}, {COLS{16'd5}});
        collectDrain(1'b0);
        nCompared++;
        if (obsCount !== ROWS) begin nMismatch++; $display("[TB] FAIL neg_rows got %0d want %0d", obsCount, ROWS); end
        for (int r = 0; r < ROWS && r < obsCount; r++) begin
            nCompared++;
            if (obsData[r] !== {COLS{16'hFFF8}}) begin nMismatch++; $display("[TB] FAIL neg_data row %0d got %h want %h", r, obsData[r], {COLS{16'hFFF8}}); end
        end
    endtask

    task automatic test_overflow();
        logic [W*COLS-1:0] want;
`ifdef CONV_MESH_SAT_EN
        want = {COLS{16'h7FFF}};
`else
        want = {COLS{16'h0002}};
`endif
        startJob(2, 0);
        beat({ROWS{16'h7FFF}}, {COLS{16'h7FFF}});
        beat({ROWS{16'h7FFF}}, {COLS{16'h7FFF}});
        collectDrain(1'b0);
        nCompared++;
        if (obsCount !== ROWS) begin nMismatch++; $display("[TB] FAIL ovf_rows got %0d want %0d", obsCount, ROWS); end
        for (int r = 0; r < ROWS && r < obsCount; r++) begin
            nCompared++;
            if (obsData[r] !== want) begin nMismatch++; $display("[TB] FAIL ovf_data row %0d got %h want %h", r, obsData[r], want); end
        end
    endtask

    task automatic test_backpressure();
        logic [W*ROWS-1:0] k;
        logic [W*COLS-1:0] n;
        logic [W*COLS-1:0] want;
        int v;
        for (int r = 0; r < ROWS; r++) k[W*r +: W] = W'(r + 1);
        for (int c = 0; c < COLS; c++) n[W*c +: W] = W'(c + 1);
        startJob(1, 0);
        beat(k, n);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b1;
        kIn      = {ROWS{16'h1234}};
        nIn      = {COLS{16'h0101}};
        for (int c = 0; c < COLS; c++) begin v = 2 * (c + 1); want[W*c +: W] = v[W-1:0]; end
        for (int i = 0; i < 5; i++) begin
            nCompared += 4;
            if (outValid !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_valid cycle %0d got %b want 1", i, outValid); end
            if (outRow !== 2'd1) begin nMismatch++; $display("[TB] FAIL bp_row cycle %0d got %0d want 1", i, outRow); end
            if (outData !== want) begin nMismatch++; $display("[TB] FAIL bp_data cycle %0d got %h want %h", i, outData, want); end
            if (outLast !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_last cycle %0d got %b want 0", i, outLast); end
            @(negedge clk);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        for (int c = 0; c < COLS; c++) begin v = 3 * (c + 1); want[W*c +: W] = v[W-1:0]; end
        nCompared += 3;
        if (outRow !== 2'd2) begin nMismatch++; $display("[TB] FAIL bp_row2 got %0d want 2", outRow); end
        if (outData !== want) begin nMismatch++; $display("[TB] FAIL bp_data2 got %h want %h", outData, want); end
        if (outLast !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_last2 got %b want 0", outLast); end
        @(negedge clk);
        for (int c = 0; c < COLS; c++) begin v = 4 * (c + 1); want[W*c +: W] = v[W-1:0]; end
        nCompared += 3;
        if (outRow !== 2'd3) begin nMismatch++; $display("[TB] FAIL bp_row3 got %0d want 3", outRow); end
        if (outData !== want) begin nMismatch++; $display("[TB] FAIL bp_data3 got %h want %h", outData, want); end
        if (outLast !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_last3 got %b want 1", outLast); end
        @(negedge clk);
        outReady = 1'b0;
        nCompared += 3;
        if (outValid !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_end_valid got %b want 0", outValid); end
        if (cfgReady !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_end_cfg_ready got %b want 1", cfgReady); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_end_busy got %b want 0", busy); end
    endtask

    task automatic test_abort();
        startJob(4, 0);
        beat({ROWS{16'h0123}}, {COLS{16'h0456}});
        beat({ROWS{16'h0789}}, {COLS{16'h0ABC}});
        rstN = 1'b0;
        #1;
        nCompared += 4;
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        if (cfgReady !== 1'b1) begin nMismatch++; $display("[TB] FAIL abort_cfg_ready got %b want 1", cfgReady); end
        if (inReady !== 1'b0) begin nMismatch++; $display("[TB] FAIL abort_in_ready got %b want 0", inReady); end
        if (outValid !== 1'b0) begin nMismatch++; $display("[TB] FAIL abort_out_valid got %b want 0", outValid); end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        startJob(1, 0);
        beat({ROWS{16'd1}}, {COLS{16'd1}});
        collectDrain(1'b0);
        nCompared++;
        if (obsCount !== ROWS) begin nMismatch++; $display("[TB] FAIL abort_rows got %0d want %0d", obsCount, ROWS); end
        for (int r = 0; r < ROWS && r < obsCount; r++) begin
            nCompared++;
            if (obsData[r] !== {COLS{16'h0001}}) begin nMismatch++; $display("[TB] FAIL abort_data row %0d got %h want %h", r, obsData[r], {COLS{16'h0001}}); end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [W*ROWS-1:0] k;
        logic [W*COLS-1:0] n;
        logic [W*COLS-1:0] want;
        int len;
        int beats;
        for (int j = 0; j < 6; j++) begin
            len   = (j == 0) ? 0 : $urandom_range(1, 6);
            beats = (len == 0) ? 1 : len;
            startJob(len, $urandom_range(0, 12));
            for (int b = 0; b < beats; b++) begin
                for (int r = 0; r < ROWS; r++) k[W*r +: W] = W'($urandom());
                for (int c = 0; c < COLS; c++) n[W*c +: W] = W'($urandom());
                if ($urandom_range(0, 2) == 0) @(negedge clk);
                beat(k, n);
            end
            collectDrain(1'b1);
            nCompared += 2;
            if (timedOut !== 1'b0) begin nMismatch++; $display("[TB] FAIL rand_timeout job %0d got %b want 0", j, timedOut); end
            if (obsCount !== ROWS) begin nMismatch++; $display("[TB] FAIL rand_rows job %0d got %0d want %0d", j, obsCount, ROWS); end
            for (int r = 0; r < ROWS && r < obsCount; r++) begin
                want = expRow(r);
                nCompared += 2;
                if (obsData[r] !== want) begin nMismatch++; $display("[TB] FAIL rand_data job %0d row %0d got %h want %h", j, r, obsData[r], want); end
                if (obsRow[r] !== r) begin nMismatch++; $display("[TB] FAIL rand_row_idx job %0d got %0d want %0d", j, obsRow[r], r); end
            end
            nCompared++;
            if (cfgReady !== 1'b1) begin nMismatch++; $display("[TB] FAIL rand_cfg_ready job %0d got %b want 1", j, cfgReady); end
        end
    endtask

    initial begin
        nCompared = 0;
        nMismatch = 0;
        rstN      = 1'b0;
        cfgValid  = 1'b0;
        cfgLen    = '0;
        cfgShift  = '0;
        inValid   = 1'b0;
        kIn       = '0;
        nIn       = '0;
        outReady  = 1'b0;
        mShift    = 0;
        modelClear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_negative_shift();
        test_overflow();
        test_backpressure();
        test_abort();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
